// File: rtl/vga_line_fetch_sched.sv
// Sprite-row fetch scheduler: pulls one sprite row per horizontal blank into the
// ping-pong line buffer, swaps banks at active-video start and steps the animation.
module vga_line_fetch_sched #(
   parameter int WORDS_PER_LINE = 5,
   parameter int ROWS_PER_FRAME = 30,
   parameter int SCALE_SHIFT    = 4,
   parameter int ANIM_FRAMES    = 6,
   parameter int FRAME_DIV      = 6,
   parameter int ADDR_W         = 10,
   parameter int DATA_W         = 32
) (
   input  logic              px_clk,
   input  logic              reset_n,
   input  logic              vsync,
   input  logic              activevideo,
   input  logic [9:0]        y_px,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              lb_we,
   output logic [2:0]        lb_waddr,
   output logic              lb_wbank,
   output logic [DATA_W-1:0] lb_wdata,
   output logic              rd_bank,
   output logic [2:0]        anim_frame,
   output logic              underrun
);

   localparam int ROW_W = 10 - SCALE_SHIFT;
   localparam int DIV_W = $clog2(FRAME_DIV);

   typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;

   state_t            state, state_nx;
   logic              av_d, vs_d;
   logic              line_start, line_end, vs_fall, vs_rise;
   logic [9:0]        y_next;
   logic [ROW_W-1:0]  target_row, trig_row, row_r, loaded_row;
   logic              line_trig, trig, busy, fetch_go, last_ack;
   logic [2:0]        count;
   logic [DIV_W-1:0]  div;
   logic              pending;
   logic [ADDR_W-1:0] base, base_nx;

   assign line_end   = av_d & ~activevideo;
   assign line_start = ~av_d & activevideo;
   assign vs_fall    = vs_d & ~vsync;
   assign vs_rise    = ~vs_d & vsync;

   // The row displayed on the next line is the one to fetch during this blank.
   assign y_next     = y_px + 10'd1;
   assign target_row = y_next[9:SCALE_SHIFT];
   assign line_trig  = line_end && (y_px < 10'd479) && (target_row != loaded_row);
   assign trig       = vs_rise || line_trig;
   assign trig_row   = vs_rise ? '0 : target_row;
   assign busy       = (state != IDLE);
   assign fetch_go   = trig && !busy;
   assign last_ack   = (state == FETCH) && mem_ack && (count == 3'(WORDS_PER_LINE - 1));
   assign base_nx    = (ADDR_W'(anim_frame) * ADDR_W'(ROWS_PER_FRAME) + ADDR_W'(trig_row))
                       * ADDR_W'(WORDS_PER_LINE);

   always_ff @(posedge px_clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (fetch_go) state_nx = FETCH;
         FETCH:   if (last_ack) state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // mem_req/mem_ack: mem_req is a valid that holds mem_addr stable until mem_ack
   // is seen high in the same cycle; each ack transfers one word with mem_rdata.
   always_comb begin
      mem_req  = (state == FETCH);
      mem_addr = '0;
      if (mem_req) mem_addr = base + ADDR_W'(count);
   end

   // vs_d resets high (vsync idle level) so reset release never fakes a vs_rise.
   always_ff @(posedge px_clk or negedge reset_n) begin
      if (!reset_n) begin
         av_d       <= 1'b0;
         vs_d       <= 1'b1;
         loaded_row <= '1;
         row_r      <= '0;
         pending    <= 1'b0;
         count      <= '0;
         div        <= '0;
         base       <= '0;
         lb_we      <= 1'b0;
         lb_waddr   <= '0;
         lb_wbank   <= 1'b0;
         lb_wdata   <= '0;
         rd_bank    <= 1'b0;
         anim_frame <= '0;
         underrun   <= 1'b0;
      end else begin
         av_d     <= activevideo;
         vs_d     <= vsync;
         underrun <= (line_start || trig) && busy;
         lb_we    <= 1'b0;
         if (fetch_go) begin
            count    <= '0;
            base     <= base_nx;
            row_r    <= trig_row;
            lb_wbank <= ~rd_bank;
         end
         if ((state == FETCH) && mem_ack) begin
            lb_we    <= 1'b1;
            lb_waddr <= count;
            lb_wdata <= mem_rdata;
            count    <= count + 3'd1;
         end
         if (state == DONE) loaded_row <= row_r;
         // A row finishing on the line_start cycle is swapped in immediately.
         if (line_start && (pending || (state == DONE))) begin
            rd_bank <= lb_wbank;
            pending <= 1'b0;
         end else if (state == DONE) begin
            pending <= 1'b1;
         end
         if (vs_fall) begin
            if (div == DIV_W'(FRAME_DIV - 1)) begin
               div        <= '0;
               anim_frame <= (anim_frame == 3'(ANIM_FRAMES - 1)) ? 3'd0 : anim_frame + 3'd1;
            end else begin
               div <= div + DIV_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_vga_line_fetch_sched.sv
// Bench for vga_line_fetch_sched: transaction-level model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_vga_line_fetch_sched;

   logic        px_clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        vsync = 1'b1;
   logic        activevideo = 1'b0;
   logic [9:0]  y_px = '0;
   logic        mem_ack = 1'b0;
   logic [31:0] mem_rdata;
   logic        mem_req;
   logic [9:0]  mem_addr;
   logic        lb_we;
   logic [2:0]  lb_waddr;
   logic        lb_wbank;
   logic [31:0] lb_wdata;
   logic        rd_bank;
   logic [2:0]  anim_frame;
   logic        underrun;

   vga_line_fetch_sched dut (
      .px_clk(px_clk), .reset_n(reset_n), .vsync(vsync), .activevideo(activevideo),
      .y_px(y_px), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
      .mem_rdata(mem_rdata), .lb_we(lb_we), .lb_waddr(lb_waddr), .lb_wbank(lb_wbank),
      .lb_wdata(lb_wdata), .rd_bank(rd_bank), .anim_frame(anim_frame), .underrun(underrun)
   );

   // clock / reset
   always #5 px_clk = ~px_clk;

   function automatic logic [31:0] mem_word(input logic [9:0] a);
      return {6'h2b, a, 6'h15, a};
   endfunction
   assign mem_rdata = mem_word(mem_addr);

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
      end
   endtask

   // model of the scheduler in terms of fetch transactions
   logic [9:0]  exp_q[$];
   logic        m_av, m_vs, m_fin, m_pending, m_rd_bank, m_wbank;
   int          m_falls, m_idx, m_loaded, m_row;
   logic [2:0]  m_anim;
   logic        e_req, e_we, e_underrun;
   logic [9:0]  e_addr;
   logic [31:0] e_waddr, e_wdata;

   always @(posedge px_clk or negedge reset_n) begin
      if (!reset_n) begin
         exp_q.delete();
         m_av = 0; m_vs = 1; m_fin = 0; m_pending = 0; m_rd_bank = 0; m_wbank = 0;
         m_falls = 0; m_idx = 0; m_loaded = -1; m_row = 0; m_anim = 0;
         e_req = 0; e_we = 0; e_underrun = 0; e_addr = 0; e_waddr = 0; e_wdata = 0;
      end else begin
         logic ls, le, vf, vr, busy, trig, set_pend;
         logic [9:0] a;
         int tgt;
         ls = !m_av && activevideo;
         le = m_av && !activevideo;
         vf = m_vs && !vsync;
         vr = !m_vs && vsync;
         busy = (exp_q.size() != 0) || m_fin;
         tgt = (int'(y_px) + 1) / 16;
         trig = vr || (le && y_px < 479 && tgt != m_loaded);
         e_underrun = (ls || trig) && busy;
         e_we = 0;
         set_pend = 0;
         if (m_fin) begin
            m_loaded = m_row;
            set_pend = 1;
            m_fin = 0;
         end else if (exp_q.size() != 0 && mem_ack) begin
            a = exp_q.pop_front();
            e_we = 1;
            e_waddr = m_idx;
            e_wdata = mem_word(a);
            m_idx++;
            if (exp_q.size() == 0) m_fin = 1;
         end
         if (trig && !busy) begin
            m_row = vr ? 0 : tgt;
            for (int i = 0; i < 5; i++) exp_q.push_back(10'((int'(m_anim) * 30 + m_row) * 5 + i));
            m_idx = 0;
            m_wbank = !m_rd_bank;
         end
         if (vf) begin
            m_falls++;
            m_anim = 3'((m_falls / 6) % 6);
         end
         if (ls && (m_pending || set_pend)) begin
            m_rd_bank = m_wbank;
            m_pending = 0;
         end else if (set_pend) begin
            m_pending = 1;
         end
         e_req = (exp_q.size() != 0);
         e_addr = e_req ? exp_q[0] : 10'd0;
         m_av = activevideo;
         m_vs = vsync;
      end
   end

   // scoreboard: every cycle, away from the active edge
   logic [9:0] seen_q[$];
   int req_cnt = 0;
   int we_b1 = 0;
   int under_cnt = 0;

   always @(negedge px_clk) begin
      if (reset_n) begin
         chk("mem_req", mem_req, e_req);
         chk("mem_addr", mem_addr, e_addr);
         chk("lb_we", lb_we, e_we);
         if (e_we) begin
            chk("lb_waddr", lb_waddr, e_waddr);
            chk("lb_wdata", lb_wdata, e_wdata);
         end
         chk("lb_wbank", lb_wbank, m_wbank);
         chk("rd_bank", rd_bank, m_rd_bank);
         chk("anim_frame", anim_frame, m_anim);
         chk("underrun", underrun, e_underrun);
         if (mem_req) req_cnt++;
         if (mem_req && mem_ack) seen_q.push_back(mem_addr);
         if (lb_we && lb_wbank) we_b1++;
         if (underrun) under_cnt++;
      end
   end

   // driver tasks
   task automatic tick(input int n);
      repeat (n) @(posedge px_clk);
      #1;
   endtask

   task automatic vs_pulse();
      vsync = 0;
      tick(3);
      vsync = 1;
      tick(12);
   endtask

   task automatic line_on(input int y);
      y_px = 10'(y);
      activevideo = 1;
      tick(20);
   endtask

   task automatic line_off();
      activevideo = 0;
      tick(20);
   endtask

   task automatic check_seen(input string name, input int base);
      chk({name, "_n"}, seen_q.size(), 5);
      for (int i = 0; i < 5 && i < seen_q.size(); i++) chk(name, seen_q[i], base + i);
   endtask

   initial begin
      int r0;
      bit found;
      tick(3);
      chk("rst_mem_req", mem_req, 0);
      chk("rst_rd_bank", rd_bank, 0);
      chk("rst_anim", anim_frame, 0);
      chk("rst_lb_we", lb_we, 0);
      reset_n = 1;
      tick(2);

      // first frame: row 0 into bank 1
      mem_ack = 1;
      seen_q.delete();
      vs_pulse();
      check_seen("row0_addr", 0);
      chk("row0_we_bank1", we_b1, 5);
      chk("row0_no_swap_yet", rd_bank, 0);
      line_on(3);
      chk("row0_swap", rd_bank, 1);
      r0 = req_cnt;
      line_off();
      chk("y3_no_fetch", req_cnt, r0);

      // row 1 into bank 0
      line_on(15);
      seen_q.delete();
      line_off();
      check_seen("row1_addr", 5);
      line_on(16);
      chk("row1_swap", rd_bank, 0);
      line_off();
      line_on(479);
      r0 = req_cnt;
      line_off();
      chk("y479_no_fetch", req_cnt, r0);

      // animation: 5 more vs_falls reach frame 1
      repeat (4) vs_pulse();
      seen_q.delete();
      vs_pulse();
      check_seen("anim1_addr", 150);
      chk("anim_after6", anim_frame, 1);
      repeat (30) vs_pulse();
      chk("anim_after36", anim_frame, 0);

      // underrun: ack withheld across line_start
      line_on(0);
      chk("pre_under_rd_bank", rd_bank, 1);
      line_off();
      mem_ack = 0;
      line_on(31);
      line_off();
      chk("stuck_req", mem_req, 1);
      chk("stuck_addr", mem_addr, 10);
      line_on(32);
      chk("under_cnt", under_cnt, 1);
      chk("under_rd_bank", rd_bank, 1);
      chk("stuck_addr_held", mem_addr, 10);
      mem_ack = 1;
      tick(3);
      line_off();
      line_on(33);
      chk("late_swap", rd_bank, 0);

      // reset after the second ack of a fetch
      y_px = 10'd47;
      tick(2);
      activevideo = 0;
      found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         tick(1);
         if (mem_req) found = 1;
      end
      chk("fetch_start_timeout", found, 1);
      chk("fetch15_addr", mem_addr, 15);
      tick(2);
      reset_n = 0;
      #1;
      chk("mid_rst_mem_req", mem_req, 0);
      chk("mid_rst_mem_addr", mem_addr, 0);
      chk("mid_rst_lb_we", lb_we, 0);
      chk("mid_rst_lb_waddr", lb_waddr, 0);
      chk("mid_rst_lb_wdata", lb_wdata, 0);
      chk("mid_rst_rd_bank", rd_bank, 0);
      chk("mid_rst_anim", anim_frame, 0);
      chk("mid_rst_underrun", underrun, 0);
      tick(3);
      reset_n = 1;
      tick(3);
      seen_q.delete();
      vs_pulse();
      check_seen("post_rst_addr", 0);
      tick(5);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
